udp_rec_pingpong: RTL

Parametrised receive-side writer for UDP payload streams. Takes the framed word stream from the UDP receive path (en_in high for the whole frame), registers it, and generates write strobes and addresses into a two-bank (ping-pong) payload RAM. On each frame end it commits the bank and reports length, truncation and drops, so the downstream SSD write logic can consume one bank while the other fills.

---
 rtl/udp_rec_pingpong.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/udp_rec_pingpong.sv
// Receive-side writer for UDP payload frames into a two-bank ping-pong RAM.
// Commits each finished frame to its bank and reports length, truncation and drops.
module udp_rec_pingpong #(
    parameter int DW   = 32,
    parameter int AW   = 12,
    parameter int SWAP = 0,
    parameter int DCW  = 16
) (
    input  logic            clk,
    input  logic            RST,
    input  logic            en_in,
    input  logic [DW-1:0]   data_in,
    input  logic [1:0]      buf_release,
    output logic [DW-1:0]   data_out,
    output logic            en_out,
    output logic [AW:0]     addr,
    output logic            frame_done,
    output logic [AW:0]     frame_len,
    output logic            frame_bank,
    output logic            frame_trunc,
    output logic [1:0]      bank_full,
    output logic [DCW-1:0]  drop_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    function automatic logic [DW-1:0] byte_swap(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < DW / 8; k++) begin
            r[8*k +: 8] = d[8*(DW/8-1-k) +: 8];
        end
        return r;
    endfunction

    state_t          state_r, state_s;
    logic            wr_bank_r, wr_bank_s;
    logic [AW:0]     count_r, count_s;
    logic            trunc_r, trunc_s;
    logic [DW-1:0]   data_r, data_s;
    logic            en_r, en_s;
    logic [AW:0]     addr_r, addr_s;
    logic            done_r, done_s;
    logic [AW:0]     len_r, len_s;
    logic            fbank_r, fbank_s;
    logic            ftrunc_r, ftrunc_s;
    logic [1:0]      bank_full_r, bank_full_s;
    logic [DCW-1:0]  drop_r, drop_s;
    logic [1:0]      set_mask_s;
    logic            drop_inc_s;
    logic            commit_s;
    logic [DW-1:0]   wr_data_s;

    assign wr_data_s = (SWAP != 0) ? byte_swap(data_in) : data_in;

    // FSM state register
    always_ff @(posedge clk) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, write-port and frame-commit decode
    always_comb begin
        state_s    = state_r;
        wr_bank_s  = wr_bank_r;
        count_s    = count_r;
        trunc_s    = trunc_r;
        data_s     = '0;
        en_s       = 1'b0;
        addr_s     = addr_r;
        done_s     = 1'b0;
        len_s      = len_r;
        fbank_s    = fbank_r;
        ftrunc_s   = ftrunc_r;
        set_mask_s = 2'b00;
        drop_inc_s = 1'b0;
        commit_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (en_in) begin
                    trunc_s = 1'b0;
                    if (!bank_full_r[wr_bank_r]) begin
                        state_s = ST_RECV;
                        en_s    = 1'b1;
                        data_s  = wr_data_s;
                        addr_s  = {wr_bank_r, {AW{1'b0}}};
                        count_s = {{AW{1'b0}}, 1'b1};
                    end else begin
                        state_s    = ST_DROP;
                        drop_inc_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (en_in) begin
                    // count_r[AW] set means the bank is already filled to the last offset
                    if (count_r[AW]) begin
                        trunc_s = 1'b1;
                        state_s = ST_DROP;
                    end else begin
                        en_s    = 1'b1;
                        data_s  = wr_data_s;
                        addr_s  = {wr_bank_r, count_r[AW-1:0]};
                        count_s = count_r + {{AW{1'b0}}, 1'b1};
                    end
                end else begin
                    commit_s = 1'b1;
                end
            end
            ST_DROP: begin
                if (en_in) begin
                    state_s = ST_DROP;
                end else if (trunc_r) begin
                    commit_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (commit_s) begin
            state_s    = ST_IDLE;
            done_s     = 1'b1;
            len_s      = count_r;
            fbank_s    = wr_bank_r;
            ftrunc_s   = trunc_r;
            set_mask_s = wr_bank_r ? 2'b10 : 2'b01;
            wr_bank_s  = ~wr_bank_r;
        end else begin
            done_s = 1'b0;
        end

        // a set on the same edge as a release of that bank takes priority
        bank_full_s = (bank_full_r & ~buf_release) | set_mask_s;

        if (drop_inc_s && !(&drop_r)) begin
            drop_s = drop_r + {{(DCW-1){1'b0}}, 1'b1};
        end else begin
            drop_s = drop_r;
        end
    end

    // Datapath and status registers
    always_ff @(posedge clk) begin
        if (RST) begin
            wr_bank_r   <= 1'b0;
            count_r     <= '0;
            trunc_r     <= 1'b0;
            data_r      <= '0;
            en_r        <= 1'b0;
            addr_r      <= '0;
            done_r      <= 1'b0;
            len_r       <= '0;
            fbank_r     <= 1'b0;
            ftrunc_r    <= 1'b0;
            bank_full_r <= 2'b00;
            drop_r      <= '0;
        end else begin
            wr_bank_r   <= wr_bank_s;
            count_r     <= count_s;
            trunc_r     <= trunc_s;
            data_r      <= data_s;
            en_r        <= en_s;
            addr_r      <= addr_s;
            done_r      <= done_s;
            len_r       <= len_s;
            fbank_r     <= fbank_s;
            ftrunc_r    <= ftrunc_s;
            bank_full_r <= bank_full_s;
            drop_r      <= drop_s;
        end
    end

    assign data_out    = data_r;
    assign en_out      = en_r;
    assign addr        = addr_r;
    assign frame_done  = done_r;
    assign frame_len   = len_r;
    assign frame_bank  = fbank_r;
    assign frame_trunc = ftrunc_r;
    assign bank_full   = bank_full_r;
    assign drop_cnt    = drop_r;

endmodule
